score_event_ctrl: RTL
=====================

// Module: score_event_ctrl
// PURPOSE
//   Upstream controller for the 4-bit score counter. Turns raw game-event levels
//   (start, hit, miss) into single-cycle inc/dec/ld pulses for the counter.
//   Saturates at 0 and MAX_SCORE using the counter's Q fed back on qscore.
//   Runs the game-level state machine and flags game_over when WIN_SCORE is reached.
// PARAMETERS
//   MAX_SCORE  4'd15  ceiling; no inc is issued while qscore == MAX_SCORE
//   WIN_SCORE  4'd10  qscore value that ends the game (must be <= MAX_SCORE)
//   HOLDOFF    2      lockout cycles after each inc/dec pulse (legal range 1..15)
// PORTS
//   clk        in   1  single clock; all logic on rising edge
//   rst_n      in   1  synchronous, active-low reset
//   start      in   1  start button level, asynchronous to clk
//   hit        in   1  score-up event level, asynchronous to clk
//   miss       in   1  score-down event level, asynchronous to clk
//   qscore     in   4  current score, taken from counter Q
//   inc        out  1  one-cycle pulse to counter Up
//   dec        out  1  one-cycle pulse to counter Dw
//   ld         out  1  one-cycle pulse to counter LD (counter loads 0)
//   game_over  out  1  high while in OVER
//   state      out  2  IDLE=0, LOAD=1, PLAY=2, OVER=3
// BEHAVIOUR
//   - Reset (rst_n low at an edge): state=IDLE; inc=dec=ld=game_over=0;
//     holdoff counter=0; all synchronizer and previous-value flops set to 1,
//     so a level held high across reset release produces no edge.
//   - Each of start/hit/miss: 2-flop synchronizer, then a previous-value flop.
//     Edge = sync_out & ~prev. Outputs are registered. If an input is first
//     sampled high at edge E0, the pulse is high in the cycle after edge E2
//     (3-cycle latency). A level held high gives exactly one edge.
//   - IDLE: on start edge go to LOAD. hit and miss edges are ignored.
//   - LOAD: ld=1 for exactly one cycle, then go to PLAY. The holdoff counter is cleared.
//   - PLAY, with holdoff==0:
//       hit edge only:  inc=1 if qscore != MAX_SCORE; otherwise drop it.
//       miss edge only: dec=1 if qscore != 0; otherwise drop it.
//       hit and miss edges in the same cycle: both cancel; no pulse.
//       After any inc/dec pulse, holdoff is loaded with HOLDOFF.
//   - PLAY, with holdoff != 0: holdoff decrements by 1 each cycle. Edges
//     arriving during holdoff are dropped, not queued.
//   - PLAY -> OVER when qscore == WIN_SCORE and holdoff==0. The holdoff guard
//     makes the check see the post-update Q.
//   - start edge in PLAY: go to LOAD (restart). Any pending holdoff is discarded.
//   - OVER: game_over=1, no inc/dec. On start edge go to LOAD; game_over drops
//     in the same cycle that ld rises.
//   - inc, dec and ld are mutually exclusive in every cycle. None is ever high
//     for more than 1 consecutive cycle.
//   - Reset mid-pulse or mid-holdoff: all outputs go 0 at the next edge and state=IDLE.
// TESTING
//   1 reset, hold start=hit=1 through release -> no ld/inc, state=IDLE
//   2 start pulse (IDLE) -> ld high 1 cycle, 3 cycles after first sample; state PLAY
//   3 PLAY qscore=3, hit pulse -> one inc; second hit 1 cycle later (in holdoff) -> dropped
//   4 qscore=0 miss -> no dec; qscore=15 (MAX) hit -> no inc; hit+miss same cycle -> none
//   5 drive qscore=10 (WIN) with holdoff=0 -> state OVER, game_over=1; hit -> no inc;
//     start -> ld and game_over=0
//   6 rst_n low during holdoff in PLAY -> next cycle all outputs 0, state=IDLE

Source files
------------

// File: rtl/score_event_ctrl.sv
// score_event_ctrl: turns start/hit/miss levels into saturating inc/dec/ld pulses and runs the game FSM
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      start button level (async)
//   i_hit        score-up event level (async)
//   i_miss       score-down event level (async)
//   i_qscore     current score fed back from the counter Q
//   o_inc        one-cycle pulse to counter Up
//   o_dec        one-cycle pulse to counter Dw
//   o_ld         one-cycle pulse to counter LD
//   o_game_over  high while in OVER
//   o_state      IDLE=0, LOAD=1, PLAY=2, OVER=3
module score_event_ctrl #(
  parameter logic [3:0] MAX_SCORE = 4'd15,
  parameter logic [3:0] WIN_SCORE = 4'd10,
  parameter int         HOLDOFF   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_hit,
  input  logic       i_miss,
  input  logic [3:0] i_qscore,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_ld,
  output logic       o_game_over,
  output logic [1:0] o_state
);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, OVER} state_t;
  localparam logic [3:0] HO = 4'(HOLDOFF);
  state_t     r_state, w_state_nx;
  logic [2:0] r_sync1, r_sync2, r_prev, w_edge;
  logic [3:0] r_hold, w_hold_nx;
  logic       r_inc, r_dec, r_ld, w_inc_nx, w_dec_nx, w_ld_nx;
  logic       w_start, w_hit, w_miss;
  // bit order {miss, hit, start}; flops reset to 1 so a level held across reset gives no edge
  assign w_edge  = r_sync2 & ~r_prev;
  assign w_start = w_edge[0];
  assign w_hit   = w_edge[1];
  assign w_miss  = w_edge[2];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_state <= IDLE;
      r_hold  <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_ld    <= 1'b0;
    end else begin
      r_sync1 <= {i_miss, i_hit, i_start};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_state_nx;
      r_hold  <= w_hold_nx;
      r_inc   <= w_inc_nx;
      r_dec   <= w_dec_nx;
      r_ld    <= w_ld_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold;
    w_inc_nx   = 1'b0;
    w_dec_nx   = 1'b0;
    w_ld_nx    = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        w_state_nx = w_start ? LOAD : r_state;
        w_ld_nx    = w_start;
      end
      LOAD: begin
        w_state_nx = PLAY;
        w_hold_nx  = '0;
      end
      default: begin
        if (w_start) begin
          w_state_nx = LOAD;
          w_ld_nx    = 1'b1;
          w_hold_nx  = '0;
        end else if (r_hold != '0) begin
          w_hold_nx = r_hold - 4'd1;
        end else if (i_qscore == WIN_SCORE) begin
          // only checked with holdoff clear, so Q already reflects the last pulse
          w_state_nx = OVER;
        end else begin
          w_inc_nx  = w_hit && !w_miss && i_qscore != MAX_SCORE;
          w_dec_nx  = w_miss && !w_hit && i_qscore != 4'd0;
          w_hold_nx = (w_inc_nx || w_dec_nx) ? HO : r_hold;
        end
      end
    endcase
  end
  assign o_inc       = r_inc;
  assign o_dec       = r_dec;
  assign o_ld        = r_ld;
  assign o_game_over = r_state == OVER;
  assign o_state     = r_state;
endmodule
